etpu_wb_frontend: RTL and testbench

Wishbone-slave front end for the `edu_tpu` compute core, sitting between the Caravel user-project Wishbone bus and the core's operand and result streams. It buffers activation/weight words written by the management CPU into an input FIFO and streams them to the core with valid/ready. It collects result words from the core into an output FIFO that the CPU reads back. It also provides run/done control, sticky error flags and an interrupt.

---
 rtl/etpu_wb_frontend.sv | 187 ++++++++++++++++++
 tb/tb_etpu_wb_frontend.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etpu_wb_frontend.sv
// Wishbone-slave front end for the edu_tpu core: CPU-written operands flow through an
// input FIFO to the core, core results flow through an output FIFO back to the CPU,
// plus run/done control, sticky error flags and an interrupt.
module etpu_wb_frontend #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned DEPTH     = 8
) (
   input  logic        caravel_wb_clk_i,
   input  logic        caravel_wb_rst_n_i,
   input  logic        caravel_wb_stb_i,
   input  logic        caravel_wb_cyc_i,
   input  logic        caravel_wb_we_i,
   input  logic [3:0]  caravel_wb_sel_i,
   input  logic [31:0] caravel_wb_adr_i,
   input  logic [31:0] caravel_wb_dat_i,
   output logic        caravel_wb_ack_o,
   output logic [31:0] caravel_wb_dat_o,
   output logic [31:0] act_data_o,
   output logic        act_valid_o,
   input  logic        act_ready_i,
   input  logic [31:0] res_data_i,
   input  logic        res_valid_i,
   output logic        res_ready_o,
   output logic        run_o,
   input  logic        done_i,
   output logic        irq_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic          ack;
   logic [31:0]   rd_data;
   logic          run, done, ovf, udf, irq_en;
   logic          run_d, done_d;
   logic [31:0]   in_mem  [DEPTH];
   logic [31:0]   out_mem [DEPTH];
   logic [AW-1:0] in_wp, in_rp, out_wp, out_rp;
   logic [LW-1:0] in_level, out_level;
   logic [31:0]   status, rdata;

   logic       hit, accept, ctrl_wr, flush;
   logic [1:0] reg_sel;
   logic       in_full, in_empty, out_full, out_empty;
   logic       act_push_req, res_pop_req;
   logic       in_push, in_pop, out_push, out_pop;
   logic       unused_bits;

   // Byte lanes and low address bits carry no information for full-word registers.
   assign unused_bits = ^{caravel_wb_sel_i, caravel_wb_adr_i[1:0]};

   assign hit     = caravel_wb_adr_i[31:4] == BASE_ADDR[31:4];
   assign accept  = caravel_wb_cyc_i & caravel_wb_stb_i & ~ack & hit;
   assign reg_sel = caravel_wb_adr_i[3:2];
   assign ctrl_wr = accept & caravel_wb_we_i & (reg_sel == 2'd0);
   assign flush   = ctrl_wr & caravel_wb_dat_i[1];

   assign in_full   = in_level == LW'(DEPTH);
   assign in_empty  = in_level == '0;
   assign out_full  = out_level == LW'(DEPTH);
   assign out_empty = out_level == '0;

   assign act_push_req = accept & caravel_wb_we_i & (reg_sel == 2'd2);
   assign res_pop_req  = accept & ~caravel_wb_we_i & (reg_sel == 2'd3);

   // Flush overrides every FIFO movement in the same cycle.
   assign in_push  = act_push_req & ~in_full & ~flush;
   assign in_pop   = act_valid_o & act_ready_i & ~flush;
   assign out_push = res_valid_i & res_ready_o & ~flush;
   assign out_pop  = res_pop_req & ~out_empty & ~flush;

   assign act_valid_o      = run & ~in_empty;
   assign act_data_o       = in_mem[in_rp];
   assign res_ready_o      = ~out_full;
   assign run_o            = run;
   assign irq_o            = done & irq_en;
   assign caravel_wb_ack_o = ack;
   assign caravel_wb_dat_o = rd_data;

   // Status word built from pre-edge state.
   always_comb begin
      status            = '0;
      status[0]         = run;
      status[1]         = done;
      status[2]         = ovf;
      status[3]         = udf;
      status[8 +: LW]   = in_level;
      status[16 +: LW]  = out_level;
   end

   // Read mux; RES returns the current head, or 0 when empty.
   always_comb begin
      rdata = '0;
      unique case (reg_sel)
         2'd0: rdata[2] = irq_en;
         2'd1: rdata = status;
         2'd2: rdata = '0;
         2'd3: rdata = out_empty ? 32'd0 : out_mem[out_rp];
         default: rdata = '0;
      endcase
   end

   // Run/done next state: a completion pulse wins over START; START only acts when idle.
   always_comb begin
      run_d  = run;
      done_d = done;
      if (ctrl_wr && caravel_wb_dat_i[4]) done_d = 1'b0;
      if (run && done_i) begin
         run_d  = 1'b0;
         done_d = 1'b1;
      end else if (ctrl_wr && caravel_wb_dat_i[0] && !run) begin
         run_d  = 1'b1;
         done_d = 1'b0;
      end
   end

   // Bus response: single-cycle ack, data only during the ack cycle.
   always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
      if (!caravel_wb_rst_n_i) begin
         ack     <= 1'b0;
         rd_data <= '0;
      end else begin
         ack     <= accept;
         rd_data <= (accept && !caravel_wb_we_i) ? rdata : 32'd0;
      end
   end

   // Control and sticky flag registers.
   always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
      if (!caravel_wb_rst_n_i) begin
         run    <= 1'b0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
         irq_en <= 1'b0;
      end else begin
         run  <= run_d;
         done <= done_d;
         if (ctrl_wr) irq_en <= caravel_wb_dat_i[2];
         ovf <= (ovf & ~(ctrl_wr & caravel_wb_dat_i[3])) | (act_push_req & in_full & ~flush);
         udf <= (udf & ~(ctrl_wr & caravel_wb_dat_i[3])) | (res_pop_req & out_empty & ~flush);
      end
   end

   // Input FIFO: CPU pushes, core pops.
   always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
      if (!caravel_wb_rst_n_i) begin
         for (int i = 0; i < int'(DEPTH); i++) in_mem[i] <= '0;
         in_wp    <= '0;
         in_rp    <= '0;
         in_level <= '0;
      end else if (flush) begin
         in_wp    <= '0;
         in_rp    <= '0;
         in_level <= '0;
      end else begin
         if (in_push) begin
            in_mem[in_wp] <= caravel_wb_dat_i;
            in_wp         <= in_wp + 1'b1;
         end
         if (in_pop) in_rp <= in_rp + 1'b1;
         in_level <= in_level + LW'(in_push) - LW'(in_pop);
      end
   end

   // Output FIFO: core pushes, CPU pops.
   always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
      if (!caravel_wb_rst_n_i) begin
         for (int i = 0; i < int'(DEPTH); i++) out_mem[i] <= '0;
         out_wp    <= '0;
         out_rp    <= '0;
         out_level <= '0;
      end else if (flush) begin
         out_wp    <= '0;
         out_rp    <= '0;
         out_level <= '0;
      end else begin
         if (out_push) begin
            out_mem[out_wp] <= res_data_i;
            out_wp          <= out_wp + 1'b1;
         end
         if (out_pop) out_rp <= out_rp + 1'b1;
         out_level <= out_level + LW'(out_push) - LW'(out_pop);
      end
   end

endmodule

// File: tb/tb_etpu_wb_frontend.sv
// Self-checking bench for etpu_wb_frontend: a register-access vector table, directed
// multi-cycle sequences, then random transactions against a queue-based model.
module tb_etpu_wb_frontend;

   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_stb = 1'b0, wb_cyc = 1'b0, wb_we = 1'b0;
   logic [31:0] wb_adr = '0, wb_dat = '0;
   logic        ack;
   logic [31:0] dat_o;
   logic [31:0] act_data;
   logic        act_valid;
   logic        act_ready = 1'b0;
   logic [31:0] res_data = '0;
   logic        res_valid = 1'b0;
   logic        res_ready;
   logic        run_o;
   logic        done_in = 1'b0;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state
   logic [31:0] in_q[$];
   logic [31:0] out_q[$];
   logic        m_run, m_done, m_ovf, m_udf, m_irq_en;

   etpu_wb_frontend #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .caravel_wb_clk_i   (clk),
      .caravel_wb_rst_n_i (rst_n),
      .caravel_wb_stb_i   (wb_stb),
      .caravel_wb_cyc_i   (wb_cyc),
      .caravel_wb_we_i    (wb_we),
      .caravel_wb_sel_i   (4'hF),
      .caravel_wb_adr_i   (wb_adr),
      .caravel_wb_dat_i   (wb_dat),
      .caravel_wb_ack_o   (ack),
      .caravel_wb_dat_o   (dat_o),
      .act_data_o         (act_data),
      .act_valid_o        (act_valid),
      .act_ready_i        (act_ready),
      .res_data_i         (res_data),
      .res_valid_i        (res_valid),
      .res_ready_o        (res_ready),
      .run_o              (run_o),
      .done_i             (done_in),
      .irq_o              (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chkb(input string name, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   // One bus access; core-side pulses set by the caller last only for the first edge.
   task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     output logic [31:0] rd, output logic acked, output int lat);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat;
      acked = 1'b0; rd = '0; lat = 0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         act_ready = 1'b0; res_valid = 1'b0; done_in = 1'b0;
         if (ack) begin
            acked = 1'b1; rd = dat_o; lat = i;
            break;
         end
      end
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      @(posedge clk); #1;
      chkb("ack_drop", ack, 1'b0);
      chk("dat_idle", dat_o, 32'd0);
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] dat);
      logic [31:0] rd; logic acked; int lat;
      wb(1'b1, BASE | 32'(off), dat, rd, acked, lat);
      chkb("wr_ack", acked, 1'b1);
   endtask

   task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
      logic [31:0] rd; logic acked; int lat;
      wb(1'b0, BASE | 32'(off), 32'd0, rd, acked, lat);
      chk({name, "_lat"}, 32'(lat), 32'd1);
      chk(name, rd, exp);
   endtask

   task automatic pulse_res(input logic [31:0] d);
      res_valid = 1'b1; res_data = d;
      @(posedge clk); #1;
      res_valid = 1'b0;
   endtask

   task automatic pulse_done();
      done_in = 1'b1;
      @(posedge clk); #1;
      done_in = 1'b0;
   endtask

   function automatic logic [31:0] m_status();
      return 32'(m_run) | (32'(m_done) << 1) | (32'(m_ovf) << 2) | (32'(m_udf) << 3)
           | (32'(in_q.size()) << 8) | (32'(out_q.size()) << 16);
   endfunction

   task automatic m_reset();
      in_q.delete(); out_q.delete();
      m_run = 0; m_done = 0; m_ovf = 0; m_udf = 0; m_irq_en = 0;
   endtask

   task automatic m_ctrl(input logic [31:0] d);
      if (d[1]) begin in_q.delete(); out_q.delete(); end
      m_irq_en = d[2];
      if (d[3]) begin m_ovf = 0; m_udf = 0; end
      if (d[4]) m_done = 0;
      if (d[0] && !m_run) begin m_run = 1; m_done = 0; end
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  off;
      logic [31:0] dat;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [31:0] rd;
      logic        acked;
      int          lat;

      tbl[0]  = '{1'b0, 4'h4, 32'h0,        32'h0};
      tbl[1]  = '{1'b1, 4'h8, 32'hA0,       32'h0};
      tbl[2]  = '{1'b1, 4'h8, 32'hA1,       32'h0};
      tbl[3]  = '{1'b1, 4'h8, 32'hA2,       32'h0};
      tbl[4]  = '{1'b0, 4'h4, 32'h0,        32'h300};
      tbl[5]  = '{1'b0, 4'h8, 32'h0,        32'h0};
      tbl[6]  = '{1'b1, 4'h0, 32'h4,        32'h0};
      tbl[7]  = '{1'b0, 4'h0, 32'h0,        32'h4};
      tbl[8]  = '{1'b1, 4'h4, 32'hFFFFFFFF, 32'h0};
      tbl[9]  = '{1'b1, 4'hC, 32'h55,       32'h0};
      tbl[10] = '{1'b0, 4'h4, 32'h0,        32'h300};
      tbl[11] = '{1'b1, 4'h0, 32'h0,        32'h0};
      tbl[12] = '{1'b0, 4'h0, 32'h0,        32'h0};

      // Reset values
      #12;
      chkb("rst_ack", ack, 1'b0);
      chk("rst_dat", dat_o, 32'd0);
      chkb("rst_run", run_o, 1'b0);
      chkb("rst_irq", irq, 1'b0);
      chkb("rst_act_valid", act_valid, 1'b0);
      chkb("rst_res_ready", res_ready, 1'b1);
      chk("rst_act_data", act_data, 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Register-access table
      foreach (tbl[i]) begin
         if (tbl[i].we) wr(tbl[i].off, tbl[i].dat);
         else rd_chk($sformatf("tbl%0d", i), tbl[i].off, tbl[i].exp);
      end
      chkb("idle_act_valid", act_valid, 1'b0);

      // START streams the three words in order, one per cycle
      wr(4'h0, 32'h1);
      chkb("start_run", run_o, 1'b1);
      act_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chkb("stream_valid", act_valid, 1'b1);
         chk("stream_data", act_data, 32'hA0 + 32'(i));
         @(posedge clk); #1;
      end
      act_ready = 1'b0;
      chkb("stream_empty", act_valid, 1'b0);
      rd_chk("stream_status", 4'h4, 32'h1);
      pulse_done();
      wr(4'h0, 32'h10);

      // Overflow on the ninth write
      for (int i = 0; i < 9; i++) wr(4'h8, 32'hC0 + 32'(i));
      rd_chk("ovf_status", 4'h4, 32'h804);
      wr(4'h0, 32'h8);
      rd_chk("clr_err_status", 4'h4, 32'h800);
      wr(4'h0, 32'h2);
      rd_chk("flush_status", 4'h4, 32'h0);

      // Result readback and underflow
      pulse_res(32'h11);
      pulse_res(32'h22);
      rd_chk("res_level", 4'h4, 32'h20000);
      rd_chk("res0", 4'hC, 32'h11);
      rd_chk("res1", 4'hC, 32'h22);
      rd_chk("res_empty", 4'hC, 32'h0);
      rd_chk("udf_status", 4'h4, 32'h8);
      wr(4'h0, 32'h8);

      // Interrupt on completion
      wr(4'h0, 32'h5);
      chkb("irq_run", run_o, 1'b1);
      chkb("irq_low", irq, 1'b0);
      pulse_done();
      chkb("done_run", run_o, 1'b0);
      chkb("done_irq", irq, 1'b1);
      wr(4'h0, 32'h14);
      chkb("clr_done_irq", irq, 1'b0);
      pulse_done();
      chkb("idle_done_irq", irq, 1'b0);
      rd_chk("idle_done_status", 4'h4, 32'h0);

      // Flush on the same edge as a core result push and an operand pop
      wr(4'h8, 32'hB0);
      wr(4'h8, 32'hB1);
      pulse_res(32'h33);
      rd_chk("pre_flush", 4'h4, 32'h10200);
      wr(4'h0, 32'h1);
      chkb("pre_flush_valid", act_valid, 1'b1);
      act_ready = 1'b1; res_valid = 1'b1; res_data = 32'h44;
      wr(4'h0, 32'h2);
      rd_chk("post_flush", 4'h4, 32'h1);

      // START and done in the same cycle: done wins
      done_in = 1'b1;
      wr(4'h0, 32'h1);
      chkb("start_done_run", run_o, 1'b0);
      rd_chk("start_done_status", 4'h4, 32'h2);

      // Reset during an ack cycle
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = BASE | 32'h4;
      @(posedge clk); #1;
      chkb("mid_ack", ack, 1'b1);
      chk("mid_dat", dat_o, 32'h2);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chkb("mid_rst_ack", ack, 1'b0);
      chk("mid_rst_dat", dat_o, 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      m_reset();

      // Random transactions against the model
      for (int n = 0; n < 400; n++) begin
         int op;
         logic [31:0] d, exp;
         op = $urandom_range(0, 8);
         d  = $urandom;
         case (op)
            0, 1: begin
               wr(4'h8, d);
               if (in_q.size() == DEPTH) m_ovf = 1;
               else in_q.push_back(d);
            end
            2: begin
               if (out_q.size() == 0) begin exp = 0; m_udf = 1; end
               else exp = out_q.pop_front();
               rd_chk("r_res", 4'hC, exp);
            end
            3: begin
               pulse_res(d);
               if (out_q.size() < DEPTH) out_q.push_back(d);
            end
            4: rd_chk("r_status", 4'h4, m_status());
            5: begin
               d = d & 32'h1F;
               if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
               wr(4'h0, d);
               m_ctrl(d);
            end
            6, 7: begin
               if (m_run && in_q.size() > 0) chk("r_act_data", act_data, in_q[0]);
               act_ready = 1'b1;
               @(posedge clk); #1;
               act_ready = 1'b0;
               if (m_run && in_q.size() > 0) void'(in_q.pop_front());
            end
            default: begin
               if (d[0]) begin
                  pulse_done();
                  if (m_run) begin m_run = 0; m_done = 1; end
               end else begin
                  wb(d[1], (BASE + 32'h10) | 32'(d[3:2] << 2), d, rd, acked, lat);
                  chkb("r_miss_ack", acked, 1'b0);
               end
            end
         endcase
         chkb("r_run", run_o, m_run);
         chkb("r_irq", irq, m_done & m_irq_en);
         chkb("r_res_ready", res_ready, out_q.size() < DEPTH);
         chkb("r_act_valid", act_valid, m_run && in_q.size() > 0);
      end
      rd_chk("r_final_status", 4'h4, m_status());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
